// File: rtl/adc_capture_multi_if.sv
// Parallel ADC front-end bus: raw sample words and controls in, processed codes, valid and rail flags out.
interface adc_capture_multi_if #(
    parameter int NCH   = 2,
    parameter int IN_W  = 10,
    parameter int OUT_W = 8
) ();
    logic                  en;
    logic [NCH*IN_W-1:0]   data_in;
    logic                  ovr_clr;
    logic [NCH*OUT_W-1:0]  code_out;
    logic                  code_valid;
    logic [NCH-1:0]        ovr;

    modport master (
        output en, data_in, ovr_clr,
        input  code_out, code_valid, ovr
    );

    modport slave (
        input  en, data_in, ovr_clr,
        output code_out, code_valid, ovr
    );
endinterface

// File: rtl/adc_capture_multi.sv
// Multi-channel ADC capture with block averaging, round-half-up/saturate to OUT_W and sticky rail flags.
// Define ADC_TWOS_COMP_EN to emit two's-complement codes instead of offset binary.
module adc_capture_multi #(
    parameter int NCH         = 2,
    parameter int IN_W        = 10,
    parameter int OUT_W       = 8,
    parameter int AVG_LOG2    = 0,
    parameter int NEG_CAPTURE = 1
) (
    input  logic                clk_AD,
    input  logic                rst,
    adc_capture_multi_if.slave  adc
);
    localparam int ACC_W = IN_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'((1 << AVG_LOG2) - 1);
    localparam int RSH = (OUT_W < IN_W) ? (IN_W - OUT_W) : 0;
    localparam int LSH = (OUT_W >= IN_W) ? (OUT_W - IN_W) : 0;
    localparam logic [IN_W:0] HALF = (IN_W+1)'((1 << RSH) >> 1);

    function automatic logic [OUT_W-1:0] round_sat(input logic [IN_W-1:0] avg);
        logic [IN_W:0]    rnd;
        logic [OUT_W-1:0] res;
        rnd = {1'b0, avg} + HALF;
        if (RSH > 0) begin
            rnd = rnd >> RSH;
            res = ((rnd >> OUT_W) != '0) ? '1 : OUT_W'(rnd);
        end else begin
            res = OUT_W'(avg) << LSH;
        end
`ifdef ADC_TWOS_COMP_EN
        res[OUT_W-1] = ~res[OUT_W-1];
`endif
        return res;
    endfunction

    logic [NCH-1:0][IN_W-1:0]  cap_p0;
    logic [NCH-1:0][ACC_W-1:0] acc_p1;
    logic [NCH-1:0][ACC_W-1:0] sum_p1;
    logic [NCH-1:0][OUT_W-1:0] rnd_p1;
    logic [NCH-1:0]            hit_p1;
    logic [CNT_W-1:0]          cnt_p1;
    logic [NCH-1:0][OUT_W-1:0] code_p2;
    logic                      vld_p2;
    logic [NCH-1:0]            ovr_p2;

    // Stage 1: pin capture on the selected ADC clock edge
    generate
        if (NEG_CAPTURE != 0) begin : g_neg_cap
            always_ff @(negedge clk_AD or posedge rst) begin
                if (rst) cap_p0 <= '0;
                else     cap_p0 <= adc.data_in;
            end
        end else begin : g_pos_cap
            always_ff @(posedge clk_AD or posedge rst) begin
                if (rst) cap_p0 <= '0;
                else     cap_p0 <= adc.data_in;
            end
        end
    endgenerate

    always_comb begin
        sum_p1 = '0;
        rnd_p1 = '0;
        hit_p1 = '0;
        for (int c = 0; c < NCH; c++) begin
            sum_p1[c] = acc_p1[c] + ACC_W'(cap_p0[c]);
            rnd_p1[c] = round_sat(IN_W'(sum_p1[c] >> AVG_LOG2));
            hit_p1[c] = (cap_p0[c] == '0) || (cap_p0[c] == '1);
        end
    end

    // Stage 2: accumulate, emit rounded block average, track rail hits
    always_ff @(posedge clk_AD or posedge rst) begin
        if (rst) begin
            acc_p1  <= '0;
            cnt_p1  <= '0;
            code_p2 <= '0;
            vld_p2  <= 1'b0;
            ovr_p2  <= '0;
        end else begin
            ovr_p2 <= (ovr_p2 & ~{NCH{adc.ovr_clr}}) | hit_p1;
            if (!adc.en) begin
                acc_p1 <= '0;
                cnt_p1 <= '0;
                vld_p2 <= 1'b0;
            end else if (cnt_p1 == CNT_TERM) begin
                acc_p1  <= '0;
                cnt_p1  <= '0;
                code_p2 <= rnd_p1;
                vld_p2  <= 1'b1;
            end else begin
                acc_p1 <= sum_p1;
                cnt_p1 <= cnt_p1 + CNT_W'(1);
                vld_p2 <= 1'b0;
            end
        end
    end

    assign adc.code_out   = code_p2;
    assign adc.code_valid = vld_p2;
    assign adc.ovr        = ovr_p2;
endmodule

// File: doc/adc_capture_multi.md
Name: adc_capture_multi

Overview:
Parametrised successor to the team's two-channel ADC front-end capture register. It captures NCH parallel ADC buses on the selected edge of the ADC clock and can average 2^AVG_LOG2 samples per channel. Results are rounded (not truncated) from IN_W to OUT_W with saturation. It flags ADC rail hits per channel and emits a one-cycle valid strobe per result. It sits between the ADC pins and the DSP/modulator chain.

Parameters:
NCH, 2, number of ADC channels
IN_W, 10, ADC input width per channel (offset binary)
OUT_W, 8, output code width per channel
AVG_LOG2, 0, log2 of samples averaged per result (0 = pass-through, max 6)
NEG_CAPTURE, 1, 1 = input register on falling edge of clk_AD, 0 = rising edge

Ports:
clk_AD  in  1  ADC sample clock; the only clock
rst  in  1  asynchronous reset, active-high
en  in  1  capture/average enable
data_in  in  NCH*IN_W  raw ADC words; channel c at [c*IN_W +: IN_W]
ovr_clr  in  1  clears all sticky overrange flags
code_out  out  NCH*OUT_W  processed codes; channel c at [c*OUT_W +: OUT_W]
code_valid  out  1  one-cycle pulse, code_out updated this cycle
ovr  out  NCH  sticky per-channel rail-hit flags

Behaviour:
- Reset (rst=1, async) clears all state: capture regs, accumulators and sample counter = 0; code_out = 0; code_valid = 0; ovr = 0.
- Stage 1: capture register samples data_in on the negedge of clk_AD (NEG_CAPTURE=1) or the posedge (0). It is reset asynchronously.
- Stage 2, posedge clk_AD: per-channel accumulator, width IN_W+AVG_LOG2, and a shared counter cnt, 0..2^AVG_LOG2-1.
- en=1, cnt < terminal: acc <= acc + s; cnt++.
- en=1, cnt = terminal: sum = acc + s; avg = sum >> AVG_LOG2 (truncate); acc <= 0; cnt <= 0.
  - code_out <= round(avg); code_valid <= 1 for exactly one cycle.
- AVG_LOG2=0: every enabled cycle produces a result, so code_valid stays high continuously.
- Rounding when OUT_W < IN_W: r = (avg + 2^(IN_W-OUT_W-1)) >> (IN_W-OUT_W), round-half-up.
  - If r overflows OUT_W bits, saturate to all-ones.
- Rounding when OUT_W >= IN_W: avg left-shifted, zero-filled; no rounding.
- Latency: NEG_CAPTURE=1 gives a result at the first posedge after the negedge capture of the block's last sample (half a cycle). NEG_CAPTURE=0 gives a result one posedge after capture.
- en=0 at a posedge: acc, cnt <= 0; code_valid <= 0; code_out holds. A partial block is discarded.
  - On the next en=1 a fresh block starts with cnt=0.
- Overrange: ovr[c] sets at a posedge when the stage-1 word of channel c is all-zeros or all-ones. This is independent of en.
  - ovr[c] stays set until ovr_clr=1.
  - Simultaneous set and ovr_clr: set wins.
- Reset asserted mid-block clears everything immediately; no partial result is emitted.
- All channels share cnt and code_valid; results for all channels update in the same cycle.

Optional Feature:
ADC_TWOS_COMP_EN
- Defined: after rounding and saturation, the MSB of each code_out channel is inverted, converting offset binary to two's complement (e.g. 8'h80 -> 8'h00, 8'hFF -> 8'h7F). ovr is unaffected.
- Undefined: code_out stays offset binary.

Test Plan:
- rst pulse mid-stream, with en=1 and data toggling -> code_out=0, code_valid=0 and ovr=0 immediately, asynchronously, with no clock edge required.
- Defaults (AVG_LOG2=0), en=1, ch0=10'h1FE, ch1=10'h001 -> next result ch0=8'h80, ch1=8'h00, code_valid high.
- Defaults, ch0=10'h3FF -> ch0=8'hFF (rounding saturates), and ovr[0]=1 persists after data returns to 10'h200.
  - Pulse ovr_clr with 10'h3FF still present -> ovr[0] stays 1.
  - Pulse ovr_clr with 10'h200 present -> ovr[0]=0.
- AVG_LOG2=2, ch0 sequence 100,101,102,103 -> single code_valid pulse after the 4th sample, ch0=8'd25. code_valid is low for the 3 preceding cycles.
- AVG_LOG2=2, drop en after 2 samples, re-enable, then feed 4 x 10'd512 -> next result 8'h80 with the partial block discarded; code_out held while en=0.
- ADC_TWOS_COMP_EN defined, ch0=10'h200 then 10'h000 -> ch0=8'h00 then 8'h80; ovr[0] set by the second sample.
